// File: rtl/reaction_ctrl_if.sv
// Trial-control signals shared by the front panel, the BCD ms counter and reaction_ctrl.
// master drives start/stop/time_late; slave (reaction_ctrl) drives counter control and result lamps.
interface reaction_ctrl_if;
  logic start;
  logic stop;
  logic time_late;
  logic time_clr;
  logic time_en;
  logic led;
  logic done;
  logic early;
  logic late;

  modport master (
    output start, stop, time_late,
    input  time_clr, time_en, led, done, early, late
  );

  modport slave (
    input  start, stop, time_late,
    output time_clr, time_en, led, done, early, late
  );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-timer trial FSM: random foreperiod, then one time_en per ms until stop/overflow; results 1 clk after the event.
// No backpressure (pulses sampled every cycle); time_en is combinational on stop; early-stop detection under RCTRL_EARLY_DET_EN.
module reaction_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int DLY_MIN_MS = 1000
) (
  input logic            clk,
  input logic            rst_n,
  reaction_ctrl_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RUN, S_DONE, S_EARLY, S_LATE} state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [15:0]   delay;
  logic [PW-1:0] presc;
  logic          tick;
  logic          clr_q;
  logic          led_q;
  logic          done_q;
  logic          late_q;
`ifdef RCTRL_EARLY_DET_EN
  logic          early_q;
`endif

  // Free-running source of the foreperiod; never reaches zero from a non-zero seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      delay   <= '0;
      presc   <= '0;
      clr_q   <= 1'b1;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
      late_q  <= 1'b0;
`ifdef RCTRL_EARLY_DET_EN
      early_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_WAIT: begin
          presc <= tick ? '0 : presc + PW'(1);
`ifdef RCTRL_EARLY_DET_EN
          // An anticipating press wins even over the final foreperiod tick.
          if (bus.stop) begin
            state   <= S_EARLY;
            presc   <= '0;
            clr_q   <= 1'b0;
            early_q <= 1'b1;
          end else
`endif
          if (tick) begin
            if (delay == 16'd1) begin
              state <= S_RUN;
              clr_q <= 1'b0;
              led_q <= 1'b1;
            end else begin
              delay <= delay - 16'd1;
            end
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            state  <= S_DONE;
            presc  <= '0;
            led_q  <= 1'b0;
            done_q <= 1'b1;
          end else if (bus.time_late) begin
            state  <= S_LATE;
            presc  <= '0;
            led_q  <= 1'b0;
            late_q <= 1'b1;
          end else begin
            presc <= tick ? '0 : presc + PW'(1);
          end
        end
        default: begin
          if (bus.start) begin
            state   <= S_WAIT;
            delay   <= 16'(DLY_MIN_MS) + {4'd0, lfsr[11:0]};
            presc   <= '0;
            clr_q   <= 1'b1;
            done_q  <= 1'b0;
            late_q  <= 1'b0;
`ifdef RCTRL_EARLY_DET_EN
            early_q <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  assign bus.time_clr = clr_q;
  assign bus.led      = led_q;
  assign bus.done     = done_q;
  assign bus.late     = late_q;
  assign bus.time_en  = led_q & tick & ~bus.stop;
`ifdef RCTRL_EARLY_DET_EN
  assign bus.early    = early_q;
`else
  assign bus.early    = 1'b0;
`endif
endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: vector table for a known-delay trial, directed corner trials and random trials vs a timing model.
module tb_reaction_ctrl;
  localparam int T    = 4;
  localparam int DMIN = 2;
  localparam int BIG  = 1 << 30;
`ifdef RCTRL_EARLY_DET_EN
  localparam bit EARLY_ON = 1'b1;
`else
  localparam bit EARLY_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  reaction_ctrl_if bus();

  reaction_ctrl #(.TICK_DIV(T), .DLY_MIN_MS(DMIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks   = 0;
  int          errors   = 0;
  int          cyc      = 0;
  int          n_en     = 0;
  int          led_cyc  = 0;
  bit          led_seen = 1'b0;
  logic [15:0] lfsr_m;

  typedef struct {
    int         n;
    bit         start;
    bit         stop;
    bit         tlate;
    logic [4:0] exp_o;
    int         en;
  } vec_t;
  vec_t tbl[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pseudo-random sequence: taps 16,14,13,11 as a parity mask.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {lfsr_m[14:0], ^(lfsr_m & 16'hB400)};
  end

  function automatic logic [4:0] outs();
    return {bus.time_clr, bus.led, bus.done, bus.early, bus.late};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic half();
    @(negedge clk);
    if (bus.time_en === 1'b1) n_en++;
    if (bus.led === 1'b1 && !led_seen) begin
      led_seen = 1'b1;
      led_cyc  = cyc;
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Offsets are in clk edges after WAIT entry; *_rel makes them relative to the end of the foreperiod.
  task automatic trial(input string nm, input bit r_use, input bit r_rel, input int r_v,
                       input bit l_rel, input int l_v);
    int waited, d, dc, w, r, l, se, le, term, exp_en, lim;
    logic [4:0] exp_o;
    bit exp_led;
    waited = 0;
    while (lfsr_m[11:0] >= 12'd8 && waited < 20000) begin
      half();
      nxt();
      waited++;
    end
    chk({nm, " short_delay"}, 32'(lfsr_m[11:0] < 12'd8), 32'd1);
    d  = DMIN + int'(lfsr_m[11:0]);
    dc = d * T;
    w  = cyc + 1;
    r  = r_rel ? dc + r_v : r_v;
    if (r < 1) r = 1;
    l  = l_rel ? dc + l_v : l_v;
    if (l < 1) l = 1;
    if (EARLY_ON && r_use && r <= dc) begin
      exp_o = 5'b00010; exp_en = 0; exp_led = 1'b0; term = r;
    end else begin
      se = (r_use && r > dc) ? r : BIG;
      le = (l > dc) ? l : dc + 1;
      exp_led = 1'b1;
      if (se <= le) begin
        exp_o = 5'b00100; exp_en = (se - dc - 1) / T; term = se;
      end else begin
        exp_o = 5'b00001; exp_en = (le - dc) / T; term = le;
      end
    end
    lim = w + term + 2 * T + 2;
    n_en = 0;
    led_seen = 1'b0;
    bus.start = 1'b1;
    half();
    nxt();
    bus.start = 1'b0;
    while (cyc < lim) begin
      bus.stop      = r_use && (cyc == w + r - 1);
      bus.time_late = (cyc >= w + l - 1);
      half();
      if (cyc == w)
        chk({nm, " wait_entry"}, {28'd0, bus.time_clr, bus.done, bus.early, bus.late}, 32'h8);
      nxt();
    end
    bus.stop      = 1'b0;
    bus.time_late = 1'b0;
    chk({nm, " outcome"}, 32'(outs()), 32'(exp_o));
    chk({nm, " strobes"}, n_en, exp_en);
    chk({nm, " led_seen"}, 32'(led_seen), 32'(exp_led));
    if (exp_led) chk({nm, " led_cycle"}, led_cyc, w + dc);
  endtask

  initial begin
    int waited, d_new, w_new, lim;
    // Known-delay trial (delay = 2 + 3 = 5 ms): start, 20-cycle foreperiod, stop after 7th strobe, restart.
    tbl[0] = '{1,  1'b1, 1'b0, 1'b0, 5'b10000, 0};
    tbl[1] = '{20, 1'b0, 1'b0, 1'b0, 5'b10000, 0};
    tbl[2] = '{1,  1'b0, 1'b0, 1'b0, 5'b01000, 0};
    tbl[3] = '{27, 1'b0, 1'b0, 1'b0, 5'b01000, 7};
    tbl[4] = '{1,  1'b0, 1'b1, 1'b0, 5'b01000, 0};
    tbl[5] = '{1,  1'b0, 1'b0, 1'b0, 5'b00100, 0};
    tbl[6] = '{5,  1'b0, 1'b0, 1'b0, 5'b00100, 0};
    tbl[7] = '{1,  1'b1, 1'b0, 1'b0, 5'b00100, 0};
    tbl[8] = '{1,  1'b0, 1'b0, 1'b0, 5'b10000, 0};
    d_new = 0;
    w_new = 0;

    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.time_late = 1'b0;
    rst_n = 1'b0;
    #1;
    repeat (2) begin half(); nxt(); end
    half();
    chk("reset_outs", 32'(outs()), 32'h10);
    chk("reset_en", 32'(bus.time_en), 32'd0);
    nxt();
    rst_n = 1'b1;
    n_en = 0;
    for (int i = 0; i < 10; i++) begin
      half();
      if (i == 9) chk("idle_outs", 32'(outs()), 32'h10);
      nxt();
    end
    chk("idle_strobes", n_en, 0);

    waited = 0;
    while (lfsr_m[11:0] != 12'd3 && waited < 30000) begin
      half();
      nxt();
      waited++;
    end
    chk("seed_wait", 32'(lfsr_m[11:0]), 32'd3);

    for (int i = 0; i < 9; i++) begin
      n_en = 0;
      for (int j = 0; j < tbl[i].n; j++) begin
        bus.start     = tbl[i].start && (j == 0);
        bus.stop      = tbl[i].stop && (j == 0);
        bus.time_late = tbl[i].tlate;
        if (bus.start) begin
          d_new    = DMIN + int'(lfsr_m[11:0]);
          w_new    = cyc + 1;
          led_seen = 1'b0;
        end
        half();
        if (j == tbl[i].n - 1) chk($sformatf("vec%0d outs", i), 32'(outs()), 32'(tbl[i].exp_o));
        nxt();
      end
      chk($sformatf("vec%0d strobes", i), n_en, tbl[i].en);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    lim = w_new + d_new * T + 4;
    while (!led_seen && cyc < lim) begin
      half();
      nxt();
    end
    chk("restart_led_seen", 32'(led_seen), 32'd1);
    chk("restart_led_cycle", led_cyc, w_new + d_new * T);

    rst_n = 1'b0;
    #1;
    chk("midrun_rst_outs", 32'(outs()), 32'h10);
    chk("midrun_rst_en", 32'(bus.time_en), 32'd0);
    nxt();
    nxt();
    rst_n = 1'b1;
    half();
    chk("post_rst_idle", 32'(outs()), 32'h10);
    nxt();

    trial("early_press", 1'b1, 1'b0, 5, 1'b1, 8 * T + 1);
    trial("late_after_40", 1'b0, 1'b0, 0, 1'b1, 40 * T + 1);
    trial("stop_on_run_tick", 1'b1, 1'b1, 3 * T, 1'b1, 20 * T);
    trial("stop_on_last_wait_tick", 1'b1, 1'b1, 0, 1'b1, 5 * T);
    trial("stop_with_late", 1'b1, 1'b1, 6 * T + 2, 1'b1, 6 * T + 2);

    for (int k = 0; k < 25; k++) begin
      bit ru;
      int rv;
      int lv;
      ru = ($urandom_range(0, 3) != 0);
      rv = int'($urandom_range(0, 20 * T)) - 6 * T;
      lv = int'($urandom_range(0, 24 * T)) - 4 * T;
      trial($sformatf("rnd%0d", k), ru, 1'b1, rv, 1'b1, lv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not complete, %0d checks so far", checks);
    $fatal(1);
  end
endmodule

// File: doc/reaction_ctrl.md
# reaction_ctrl

Trial controller for the human reaction timer. Sits directly upstream of the four-digit BCD millisecond counter: it arms a trial on `start`, waits a pseudo-random foreperiod, lights the stimulus LED, and then drives `time_clr`/`time_en` so the counter advances exactly once per millisecond until `stop` is pressed. It consumes the counter's `time_late` flag and reports the outcome of each trial as done, early or late.

## Interface
- `TICK_DIV`, 100000: clk cycles per 1 ms tick; must be 2 or more.
- `DLY_MIN_MS`, 1000: minimum foreperiod in ms; `DLY_MIN_MS + 4095` must be at most 65535.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse, already debounced; begins a trial.
- `stop` in 1: one-cycle pulse, already debounced; the subject's response.
- `time_late` in 1: overflow flag from the BCD counter, 10 s elapsed.
- `time_clr` out 1: synchronous clear to the BCD counter.
- `time_en` out 1: one-cycle count strobe to the BCD counter, one per ms while running.
- `led` out 1: stimulus lamp.
- `done` out 1: valid reaction captured.
- `early` out 1: stop pressed before the stimulus.
- `late` out 1: no response within 9.999 s.

## Operation
- The reset is asynchronous and active-low, on `rst_n`; all logic runs on the single clock `clk`.
- The state machine has six states: IDLE, WAIT, RUN, DONE, EARLY and LATE.
- **IDLE**: on `start`, load the delay register, clear the prescaler and go to WAIT.
- **WAIT**: on each tick, decrement the delay.
  - Tick with delay == 1: go to RUN and clear the prescaler.
  - `stop`: go to EARLY.
- **RUN**:
  - `stop`: go to DONE.
  - `time_late` == 1: go to LATE.
- **DONE, EARLY, LATE**: hold. On `start`, begin a new trial exactly as from IDLE.
- `start` is ignored in WAIT and RUN. `stop` is ignored in IDLE, DONE, EARLY and LATE.
- **LFSR**: 16-bit Fibonacci, taps 16, 14, 13, 11, seed 16'hACE1. It advances every clk cycle out of reset and never takes the all-zero value.
- **Delay load**: delay = `DLY_MIN_MS` + lfsr[11:0], sampled in the same cycle `start` is accepted. Delay register is 16 bits unsigned.
- **Prescaler**:
  - Counts 0 to `TICK_DIV-1`; tick = (count == `TICK_DIV-1`), then wraps to 0.
  - Forced to 0 on entry to WAIT and on entry to RUN.
- **Outputs**, decoded from the registered state:
  - `time_clr` = IDLE or WAIT.
  - `led` = RUN.
  - `done` = DONE.
  - `early` = EARLY.
  - `late` = LATE.
- **`time_en`** = RUN and tick and not `stop`. It is the only combinational path from an input to an output.
- **Simultaneous events**:
  - `stop` with the final WAIT tick: result is EARLY.
  - `stop` with a RUN tick: result is DONE and no strobe is issued.
  - `stop` with `time_late`: result is DONE.
- **Reset mid-trial**: the FSM returns to IDLE immediately and all outputs take their reset values. The counter is cleared by `time_clr` from the first clk edge after release.

## Timing
- **Reset values**:
  - State is IDLE and the prescaler is 0.
  - `time_clr`=1.
  - `time_en`=0, `led`=0, `done`=0, `early`=0, `late`=0.
- **Start to WAIT**: `start` sampled at edge N gives state WAIT from N+1; `time_clr` stays 1 throughout WAIT.
- **Foreperiod**: RUN begins exactly delay×`TICK_DIV` cycles after WAIT entry; `led` and `time_clr`=0 change in the same cycle.
- **First strobe**: the first `time_en` occurs `TICK_DIV` cycles after RUN entry, then every `TICK_DIV` cycles.
- **Stop**: `stop` at edge M makes `led` fall and `done` rise at M+1. The counter holds the number of full ms elapsed.
- **Late**: `time_late` seen at edge L gives `late` at L+1; no further strobes are issued.

## Configuration
- **`RCTRL_EARLY_DET_EN` defined**: early detection as described above.
- **`RCTRL_EARLY_DET_EN` not defined**:
  - `stop` in WAIT is ignored.
  - EARLY is unreachable and `early` is tied to 0.

## Test plan
Bench parameters are `TICK_DIV`=4 and `DLY_MIN_MS`=2.
- **Reset**: hold `rst_n`=0 -> `time_clr`=1, all other outputs 0. Release, then 10 idle cycles -> state IDLE, no strobes.
- **Normal trial**: `start` pulse with lfsr[11:0] forced/known = 3.
  - `led` rises exactly 20 cycles after WAIT entry.
  - `stop` after the 7th `time_en` -> `done`=1 and exactly 7 strobes issued.
- **Early press**: `stop` 5 cycles into WAIT -> `early`=1 next cycle, `led` never rises, 0 strobes. With the macro undefined -> trial continues to RUN.
- **Late**: no `stop`; drive `time_late`=1 after 40 strobes -> `late`=1 next cycle, `time_en` stays 0 thereafter.
- **Collisions**:
  - `stop` coincident with a RUN tick -> `time_en`=0 that cycle, DONE.
  - `stop` coincident with the final WAIT tick -> EARLY.
- **Restart and reset**:
  - From DONE, `start` -> `time_clr`=1 next cycle and a new delay is loaded.
  - `rst_n` pulsed low in RUN -> `led`=0 asynchronously, IDLE.
